fifo_access_sched: RTL and testbench

- Scheduler for the lab FIFO datapath: one single-port 2**ADDR_W x DATA_W RAM, 16-bit LFSR scrambler as data source, switch-driven read/write requests.
- Generates write and read tick enables internally from CLOCK_50.
- Latches the requests on those ticks and arbitrates them onto the single RAM port.
- Owns the wraddr/rdaddr pointers and the full/empty flags, and steps the LFSR once per committed write.
- Replaces the separate divided clocks with clock enables, so the whole design runs on one clock.

---
 rtl/fifo_access_sched.sv | 163 ++++++++++++++++
 tb/tb_fifo_access_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_access_sched.sv
// Single-port FIFO RAM scheduler: tick-latched wr/rd requests, write first on a tie unless the last grant was a write.
// Latency from tick T: write in RAM at T+2, read data valid at T+4; no backpressure, full/empty requests are dropped.
// FIFO_ERR_FLAGS_EN adds sticky ovf_err/udf_err outputs flagging those drops.
module fifo_access_sched #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 16,
    parameter int WR_TICK_CYC = 100000000,
    parameter int RD_TICK_CYC = 50000000
) (
    input  logic              CLOCK_50,
    input  logic              KEY0,
    input  logic              wr_sw,
    input  logic              rd_sw,
    input  logic              scram_en,
    input  logic [DATA_W-1:0] lfsr_data,
    output logic              lfsr_step,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] wraddr,
    output logic [ADDR_W-1:0] rdaddr,
    output logic [ADDR_W-1:0] count,
    output logic              full,
    output logic              empty
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic              ovf_err,
    output logic              udf_err
`endif
);

    localparam int WCW = $clog2(WR_TICK_CYC);
    localparam int RCW = $clog2(RD_TICK_CYC);
    localparam logic [WCW-1:0]    WR_LAST = WCW'(WR_TICK_CYC - 1);
    localparam logic [RCW-1:0]    RD_LAST = RCW'(RD_TICK_CYC - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD_A, S_RD_D} state_t;

    state_t              state_q, state_d;
    logic [WCW-1:0]      wr_cnt_q, wr_cnt_d;
    logic [RCW-1:0]      rd_cnt_q, rd_cnt_d;
    logic                wr_pend_q, wr_pend_d;
    logic                rd_pend_q, rd_pend_d;
    logic                last_wr_q, last_wr_d;
    logic [ADDR_W-1:0]   wraddr_q, wraddr_d;
    logic [ADDR_W-1:0]   rdaddr_q, rdaddr_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_vld_q, rd_vld_d;
    logic                wr_tick, rd_tick;
    logic                wr_clr, rd_clr;

    assign wr_tick  = (wr_cnt_q == WR_LAST);
    assign rd_tick  = (rd_cnt_q == RD_LAST);
    assign wr_cnt_d = wr_tick ? '0 : wr_cnt_q + WCW'(1);
    assign rd_cnt_d = rd_tick ? '0 : rd_cnt_q + RCW'(1);

    assign wraddr   = wraddr_q;
    assign rdaddr   = rdaddr_q;
    assign count    = wraddr_q - rdaddr_q;
    assign full     = ((wraddr_q + PTR_ONE) == rdaddr_q);
    assign empty    = (wraddr_q == rdaddr_q);
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_vld_q;

    always_comb begin
        state_d   = state_q;
        wraddr_d  = wraddr_q;
        rdaddr_d  = rdaddr_q;
        last_wr_d = last_wr_q;
        rd_data_d = rd_data_q;
        rd_vld_d  = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        lfsr_step = 1'b0;
        wr_clr    = 1'b0;
        rd_clr    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Requests that cannot be served are consumed without touching the RAM.
                if (wr_pend_q && (!rd_pend_q || !last_wr_q)) begin
                    wr_clr = 1'b1;
                    if (!full) state_d = S_WR;
                end else if (rd_pend_q) begin
                    rd_clr = 1'b1;
                    if (!empty) state_d = S_RD_A;
                end
            end
            S_WR: begin
                mem_addr  = wraddr_q;
                mem_we    = 1'b1;
                mem_wdata = lfsr_data;
                lfsr_step = scram_en;
                wraddr_d  = wraddr_q + PTR_ONE;
                last_wr_d = 1'b1;
                state_d   = S_IDLE;
            end
            S_RD_A: begin
                mem_addr = rdaddr_q;
                state_d  = S_RD_D;
            end
            S_RD_D: begin
                rd_data_d = mem_rdata;
                rd_vld_d  = 1'b1;
                rdaddr_d  = rdaddr_q + PTR_ONE;
                last_wr_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A tick seen while its side is already pending is ignored.
        wr_pend_d = wr_pend_q ? !wr_clr : (wr_tick && wr_sw);
        rd_pend_d = rd_pend_q ? !rd_clr : (rd_tick && rd_sw);
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state_q   <= S_IDLE;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            wr_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
            last_wr_q <= 1'b0;
            wraddr_q  <= '0;
            rdaddr_q  <= '0;
            rd_data_q <= '0;
            rd_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_pend_q <= wr_pend_d;
            rd_pend_q <= rd_pend_d;
            last_wr_q <= last_wr_d;
            wraddr_q  <= wraddr_d;
            rdaddr_q  <= rdaddr_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, udf_q;

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (wr_clr & full);
            udf_q <= udf_q | (rd_clr & empty);
        end
    end

    assign ovf_err = ovf_q;
    assign udf_err = udf_q;
`endif

endmodule

// File: tb/tb_fifo_access_sched.sv
// Bench for fifo_access_sched: RAM/LFSR environment plus a cycle-timeline reference model of the FIFO.
module tb_fifo_access_sched;

    localparam int AW    = 3;
    localparam int DW    = 16;
    localparam int WRC   = 8;
    localparam int RDC   = 4;
    localparam int DEPTH = (1 << AW) - 1;

    logic          CLOCK_50 = 1'b0;
    logic          KEY0     = 1'b1;
    logic          wr_sw    = 1'b0;
    logic          rd_sw    = 1'b0;
    logic          scram_en = 1'b0;
    logic [DW-1:0] lfsr_data;
    logic          lfsr_step;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW-1:0] wraddr, rdaddr, count;
    logic          full, empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic          ovf_err, udf_err;
`endif

    fifo_access_sched #(.ADDR_W(AW), .DATA_W(DW), .WR_TICK_CYC(WRC), .RD_TICK_CYC(RDC)) dut (
        .CLOCK_50(CLOCK_50), .KEY0(KEY0), .wr_sw(wr_sw), .rd_sw(rd_sw), .scram_en(scram_en),
        .lfsr_data(lfsr_data), .lfsr_step(lfsr_step), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rd_data(rd_data), .rd_valid(rd_valid),
        .wraddr(wraddr), .rdaddr(rdaddr), .count(count), .full(full), .empty(empty)
`ifdef FIFO_ERR_FLAGS_EN
        , .ovf_err(ovf_err), .udf_err(udf_err)
`endif
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Single-port synchronous RAM with one cycle read latency.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge CLOCK_50) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    logic [DW-1:0] env_lfsr;
    bit            env_step;
    assign lfsr_data = env_lfsr;

    function automatic logic [DW-1:0] lfsr_next(input logic [DW-1:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Reference model: words committed/consumed and the cycles at which each operation lands.
    int            cyc, n_wr, n_rd, free_at, w_cyc, w_done, r_cyc, r_done;
    bit            m_wpend, m_rpend, m_lastwr;
    logic [DW-1:0] m_lfsr, exp_rd;
    logic [DW-1:0] mq[$];
    int            n_checks, n_fail;
    int            step_cnt, rv_cnt, last_we_cyc, last_rv_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic model_reset();
        cyc = 0; n_wr = 0; n_rd = 0; free_at = 0;
        w_cyc = -1; w_done = -1; r_cyc = -1; r_done = -1;
        m_wpend = 0; m_rpend = 0; m_lastwr = 0;
        exp_rd = '0; mq.delete(); env_step = 0;
    endtask

    task automatic model_cycle();
        int occ;
        bit exp_we, wclr, rclr;
        if (cyc == w_done) n_wr++;
        if (cyc == r_done) begin exp_rd = mq.pop_front(); n_rd++; end
        occ    = n_wr - n_rd;
        exp_we = (cyc == w_cyc);
        chk("wraddr",    32'(wraddr),    32'(n_wr % (1 << AW)));
        chk("rdaddr",    32'(rdaddr),    32'(n_rd % (1 << AW)));
        chk("count",     32'(count),     32'(occ));
        chk("empty",     32'(empty),     32'(occ == 0));
        chk("full",      32'(full),      32'(occ == DEPTH));
        chk("mem_we",    32'(mem_we),    32'(exp_we));
        chk("lfsr_step", 32'(lfsr_step), 32'(exp_we && scram_en));
        chk("rd_valid",  32'(rd_valid),  32'(cyc == r_done));
        chk("rd_data",   32'(rd_data),   32'(exp_rd));
        if (exp_we) begin
            chk("wr_addr", 32'(mem_addr),  32'(n_wr % (1 << AW)));
            chk("wr_data", 32'(mem_wdata), 32'(m_lfsr));
            mq.push_back(m_lfsr);
            if (scram_en) m_lfsr = lfsr_next(m_lfsr);
        end
        if (cyc == r_cyc) chk("rd_addr", 32'(mem_addr), 32'(n_rd % (1 << AW)));
        env_step = lfsr_step;
        if (lfsr_step) step_cnt++;
        if (mem_we) last_we_cyc = cyc;
        if (rd_valid) begin rv_cnt++; last_rv_cyc = cyc; end
        wclr = 0; rclr = 0;
        if (cyc >= free_at) begin
            if (m_wpend && (!m_rpend || !m_lastwr)) begin
                wclr = 1;
                if (occ < DEPTH) begin
                    w_cyc = cyc + 1; w_done = cyc + 2; free_at = cyc + 2; m_lastwr = 1;
                end
            end else if (m_rpend) begin
                rclr = 1;
                if (occ > 0) begin
                    r_cyc = cyc + 1; r_done = cyc + 3; free_at = cyc + 3; m_lastwr = 0;
                end
            end
        end
        m_wpend = m_wpend ? !wclr : ((cyc % WRC == WRC - 1) && wr_sw);
        m_rpend = m_rpend ? !rclr : ((cyc % RDC == RDC - 1) && rd_sw);
    endtask

    task automatic step(input bit w, input bit r, input bit s);
        @(posedge CLOCK_50);
        #1;
        if (env_step) env_lfsr = lfsr_next(env_lfsr);
        env_step = 0;
        cyc++;
        wr_sw = w; rd_sw = r; scram_en = s;
        @(negedge CLOCK_50);
        model_cycle();
    endtask

    task automatic do_reset();
        wr_sw = 0; rd_sw = 0;
        KEY0 = 1'b0;
        repeat (3) begin
            @(negedge CLOCK_50);
            chk("rst_mem_we",    32'(mem_we),    0);
            chk("rst_lfsr_step", 32'(lfsr_step), 0);
            chk("rst_mem_addr",  32'(mem_addr),  0);
            chk("rst_mem_wdata", 32'(mem_wdata), 0);
            chk("rst_wraddr",    32'(wraddr),    0);
            chk("rst_rdaddr",    32'(rdaddr),    0);
            chk("rst_count",     32'(count),     0);
            chk("rst_empty",     32'(empty),     1);
            chk("rst_full",      32'(full),      0);
            chk("rst_rd_valid",  32'(rd_valid),  0);
            chk("rst_rd_data",   32'(rd_data),   0);
        end
        @(posedge CLOCK_50);
        #3 KEY0 = 1'b1;
        model_reset();
        @(negedge CLOCK_50);
        model_cycle();
    endtask

    // Waits so the requested cycle carries both a write and a read tick.
    task automatic pulse_req(input bit w, input bit r, output int t);
        int n;
        n = 0;
        while (((cyc + 1) % WRC != WRC - 1) && n < 16) begin step(0, 0, 1); n++; end
        step(w, r, 1);
        t = cyc;
        repeat (10) step(0, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, s0, r0, n;
        n_checks = 0; n_fail = 0; step_cnt = 0; rv_cnt = 0;
        last_we_cyc = -1; last_rv_cyc = -1;
        env_lfsr = 16'hACE1; m_lfsr = 16'hACE1;
        model_reset();
        #2;
        do_reset();
`ifdef FIFO_ERR_FLAGS_EN
        chk("rst_ovf", 32'(ovf_err), 0);
        chk("rst_udf", 32'(udf_err), 0);
`endif

        repeat (40) step(0, 1, 1);
        chk("empty_rdaddr", 32'(rdaddr), 0);
        chk("empty_rv_cnt", 32'(rv_cnt), 0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("empty_udf", 32'(udf_err), 1);
`endif

        s0 = step_cnt;
        repeat (88) step(1, 0, 1);
        chk("fill_wraddr", 32'(wraddr), 7);
        chk("fill_count",  32'(count),  7);
        chk("fill_full",   32'(full),   1);
        chk("fill_steps",  32'(step_cnt - s0), 7);
        chk("fill_rdaddr", 32'(rdaddr), 0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("fill_ovf", 32'(ovf_err), 1);
`endif

        r0 = rv_cnt;
        repeat (44) step(0, 1, 1);
        chk("drain_rv_cnt", 32'(rv_cnt - r0), 7);
        chk("drain_rdaddr", 32'(rdaddr), 7);
        chk("drain_empty",  32'(empty), 1);

        repeat (4) pulse_req(1, 0, t);
        pulse_req(0, 1, t);
        chk("arb1_count", 32'(count), 3);
        pulse_req(1, 1, t);
        chk("arb1_we_cyc", 32'(last_we_cyc), 32'(t + 2));
        chk("arb1_rv_cyc", 32'(last_rv_cyc), 32'(t + 6));
        pulse_req(0, 1, t);
        pulse_req(1, 0, t);
        chk("arb2_count", 32'(count), 3);
        pulse_req(1, 1, t);
        chk("arb2_rv_cyc", 32'(last_rv_cyc), 32'(t + 4));
        chk("arb2_we_cyc", 32'(last_we_cyc), 32'(t + 5));

        repeat (1500) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0));

        repeat (60) step(0, 1, 1);
        n = 0;
        while (w_cyc != cyc + 1 && n < 64) begin step(1, 0, 1); n++; end
        chk("midop_reach", 32'(n < 64), 1);
        @(posedge CLOCK_50);
        #1;
        if (env_step) env_lfsr = lfsr_next(env_lfsr);
        env_step = 0;
        cyc++;
        chk("midop_in_wr", 32'(mem_we), 1);
        #1 KEY0 = 1'b0;
        #1;
        chk("midop_we_drop",   32'(mem_we),    0);
        chk("midop_no_step",   32'(lfsr_step), 0);
        chk("midop_wraddr",    32'(wraddr),    0);
        do_reset();
        repeat (24) step(1, 0, 1);
        chk("post_rst_wraddr", 32'(wraddr), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
